// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex UART transceiver with TX/RX FIFOs.
//
// Ports
//   CLK, RST_N            : core clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready : TX byte push stream (bits above DATA_BITS ignored)
//   rx_data/rx_perr/rx_ferr/rx_valid/rx_ready : RX pop stream, first-word
//                           fall-through; data and flags are 0 while empty
//   rx_overrun            : one-clock pulse when a received word is dropped
//   tx_busy               : TX FIFO not empty or a frame still on the line
//   uart_tx / uart_rx     : serial pins, idle high; uart_rx is asynchronous
//   dbg_tx_state / dbg_rx_state : current FSM states for observation
//
// Handshakes: a word moves on a rising CLK edge where valid && ready are both
// high. valid must not depend on ready; a producer holds its word until it is
// taken. A push while full and a pop while empty are ignored.

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push+pop on full is legal.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

module uart_txrx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       tx_busy,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic [2:0] dbg_tx_state,
  output logic [2:0] dbg_rx_state
);
  localparam int   BAUD_DIV = (CLK_HZ + 8*BAUD) / (16*BAUD);
  localparam int   BIT_CLKS = 16*BAUD_DIV;
  localparam int   CNT_W    = $clog2(BIT_CLKS);
  localparam int   DIV_W    = $clog2(BAUD_DIV);
  localparam logic ODD      = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAITHI} rx_state_t;

  // ---------------- TX ----------------
  logic                 tx_empty, tx_full, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data[DATA_BITS-1:0]),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  assign tx_ready = !tx_full;

  tx_state_t            tx_state, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
  logic [2:0]           tx_idx, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_line_d, tx_line_busy;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt == CNT_W'(BIT_CLKS-1));

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 1'b1;
    tx_idx_d   = tx_idx;
    tx_sh_d    = tx_sh;
    tx_par_d   = tx_par;
    tx_pop     = 1'b0;
    tx_line_d  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_head;
          tx_par_d   = ^tx_head ^ ODD;
          tx_pop     = 1'b1;
        end
      end
      TX_START: begin
        tx_line_d = 1'b0;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line_d = tx_sh[0];
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_sh_d  = tx_sh >> 1;
          if (tx_idx == 3'(DATA_BITS-1)) begin
            tx_idx_d   = '0;
            tx_state_d = (PARITY != 0) ? TX_PAR : TX_STOP;
          end else begin
            tx_idx_d = tx_idx + 1'b1;
          end
        end
      end
      TX_PAR: begin
        tx_line_d = tx_par;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx == 3'(STOP_BITS-1)) begin
            tx_idx_d = '0;
            // Next word queued: go straight to its start bit, no idle gap.
            if (!tx_empty) begin
              tx_state_d = TX_START;
              tx_sh_d    = tx_head;
              tx_par_d   = ^tx_head ^ ODD;
              tx_pop     = 1'b1;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_idx_d = tx_idx + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // uart_tx is registered from the current state, so the line trails the FSM
  // by one clock; tx_line_busy covers that trailing clock for tx_busy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_sh        <= '0;
      tx_par       <= 1'b0;
      uart_tx      <= 1'b1;
      tx_line_busy <= 1'b0;
    end else begin
      tx_state     <= tx_state_d;
      tx_cnt       <= tx_cnt_d;
      tx_idx       <= tx_idx_d;
      tx_sh        <= tx_sh_d;
      tx_par       <= tx_par_d;
      uart_tx      <= tx_line_d;
      tx_line_busy <= (tx_state != TX_IDLE);
    end
  end

  assign tx_busy      = !tx_empty || (tx_state != TX_IDLE) || tx_line_busy;
  assign dbg_tx_state = tx_state;

  // ---------------- RX ----------------
  logic                 rx_s1, rx_s2;
  rx_state_t            rx_state, rx_state_d;
  logic [DIV_W-1:0]     rx_div, rx_div_d;
  logic [3:0]           rx_tick, rx_tick_d;
  logic [2:0]           rx_idx, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_push, rx_tick_en, rx_sample;
  logic                 rx_empty, rx_full;
  logic [DATA_BITS+1:0] rx_word, rx_head;

  assign rx_tick_en = (rx_div == DIV_W'(BAUD_DIV-1));
  // The tick counter is zeroed at the start edge; tick 8 is the start-bit
  // centre and, as the 4-bit counter wraps, every 16 ticks after that too.
  assign rx_sample  = rx_tick_en && (rx_tick == 4'd7);

  always_comb begin
    rx_state_d = rx_state;
    rx_div_d   = rx_tick_en ? '0 : rx_div + 1'b1;
    rx_tick_d  = rx_tick_en ? rx_tick + 1'b1 : rx_tick;
    rx_idx_d   = rx_idx;
    rx_sh_d    = rx_sh;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    rx_word    = {~rx_s2, rx_perr_q, rx_sh};
    case (rx_state)
      RX_IDLE: begin
        rx_div_d  = '0;
        rx_tick_d = '0;
        rx_perr_d = 1'b0;
        if (!rx_s2) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_sample) begin
          rx_idx_d   = '0;
          rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_sh_d = {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == 3'(DATA_BITS-1)) begin
            rx_idx_d   = '0;
            rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_idx_d = rx_idx + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (rx_sample) begin
          rx_perr_d  = rx_s2 ^ (^rx_sh) ^ ODD;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_push    = 1'b1;
          rx_state_d = RX_WAITHI;
        end
      end
      RX_WAITHI: begin
        // Hold here through a break so it yields only one word.
        if (rx_s2) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_div     <= '0;
      rx_tick    <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      rx_perr_q  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_state   <= rx_state_d;
      rx_div     <= rx_div_d;
      rx_tick    <= rx_tick_d;
      rx_idx     <= rx_idx_d;
      rx_sh      <= rx_sh_d;
      rx_perr_q  <= rx_perr_d;
      rx_overrun <= rx_push && rx_full && !rx_ready;
    end
  end

  uart_fifo #(.W(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (rx_push),
    .wdata (rx_word),
    .pop   (rx_ready),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign rx_valid     = !rx_empty;
  assign rx_perr      = rx_valid && rx_head[DATA_BITS];
  assign rx_ferr      = rx_valid && rx_head[DATA_BITS+1];
  assign dbg_rx_state = rx_state;

  always_comb begin
    rx_data = '0;
    if (rx_valid) rx_data[DATA_BITS-1:0] = rx_head[DATA_BITS-1:0];
  end
endmodule

// File: tb/tb_uart_txrx.sv
module tb_uart_txrx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt = 0;

  logic rst_n, rst_c;

  // DUT A: defaults, looped back
  logic [7:0] tx_data_a;
  logic       tx_valid_a, tx_ready_a, rx_ready_a;
  logic [7:0] rx_data_a;
  logic       rx_perr_a, rx_ferr_a, rx_valid_a, rx_overrun_a, tx_busy_a, uart_tx_a;
  logic [2:0] dbg_tx_a, dbg_rx_a;

  // DUT B: 7E2, bit = 32 clocks
  logic       tx_ready_b, rx_ready_b, rx_line_b;
  logic [7:0] rx_data_b;
  logic       rx_perr_b, rx_ferr_b, rx_valid_b, rx_overrun_b, tx_busy_b, uart_tx_b;
  logic [2:0] dbg_tx_b, dbg_rx_b;

  // DUT C: 8N1, FIFO_DEPTH 4, bit = 32 clocks
  logic [7:0] tx_data_c;
  logic       tx_valid_c, tx_ready_c, rx_ready_c, rx_line_c;
  logic [7:0] rx_data_c;
  logic       rx_perr_c, rx_ferr_c, rx_valid_c, rx_overrun_c, tx_busy_c, uart_tx_c;
  logic [2:0] dbg_tx_c, dbg_rx_c;

  uart_txrx u_a (
    .CLK(clk), .RST_N(rst_n),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_overrun(rx_overrun_a),
    .tx_busy(tx_busy_a), .uart_tx(uart_tx_a), .uart_rx(uart_tx_a),
    .dbg_tx_state(dbg_tx_a), .dbg_rx_state(dbg_rx_a)
  );

  uart_txrx #(.CLK_HZ(3200000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .CLK(clk), .RST_N(rst_n),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_overrun(rx_overrun_b),
    .tx_busy(tx_busy_b), .uart_tx(uart_tx_b), .uart_rx(rx_line_b),
    .dbg_tx_state(dbg_tx_b), .dbg_rx_state(dbg_rx_b)
  );

  uart_txrx #(.CLK_HZ(3200000), .BAUD(100000), .FIFO_DEPTH(4)) u_c (
    .CLK(clk), .RST_N(rst_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .rx_data(rx_data_c), .rx_perr(rx_perr_c), .rx_ferr(rx_ferr_c),
    .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_overrun(rx_overrun_c),
    .tx_busy(tx_busy_c), .uart_tx(uart_tx_c), .uart_rx(rx_line_c),
    .dbg_tx_state(dbg_tx_c), .dbg_rx_state(dbg_rx_c)
  );

  always @(negedge clk) if (rx_overrun_c === 1'b1) ovr_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic b_bit(input logic v);
    rx_line_b = v;
    tick(32);
  endtask

  task automatic b_frame(input logic [6:0] d, input logic p);
    b_bit(1'b0);
    for (int i = 0; i < 7; i++) b_bit(d[i]);
    b_bit(p);
    b_bit(1'b1);
    b_bit(1'b1);
  endtask

  task automatic c_bit(input logic v);
    rx_line_c = v;
    tick(32);
  endtask

  task automatic c_frame(input logic [7:0] d, input logic stop);
    c_bit(1'b0);
    for (int i = 0; i < 8; i++) c_bit(d[i]);
    c_bit(stop);
  endtask

  task automatic pop_a;
    rx_ready_a = 1'b1; tick(1); rx_ready_a = 1'b0;
  endtask

  task automatic pop_b;
    rx_ready_b = 1'b1; tick(1); rx_ready_b = 1'b0;
  endtask

  task automatic pop_c;
    rx_ready_c = 1'b1; tick(1); rx_ready_c = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_a [3];
    logic [7:0] exp_c [4];
    logic [9:0] frame_7e;
    int ovr_start;
    exp_a = '{8'h55, 8'hA3, 8'h0D};
    exp_c = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame_7e = {1'b1, 8'h7E, 1'b0};

    rst_n = 1'b0; rst_c = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
    rx_ready_b = 1'b0; rx_line_b = 1'b1;
    tx_data_c = '0; tx_valid_c = 1'b0; rx_ready_c = 1'b0; rx_line_c = 1'b1;
    tick(3);

    check("reset_uart_tx",    uart_tx_a,    1);
    check("reset_tx_ready",   tx_ready_a,   1);
    check("reset_tx_busy",    tx_busy_a,    0);
    check("reset_rx_valid",   rx_valid_a,   0);
    check("reset_rx_data",    rx_data_a,    0);
    check("reset_rx_perr",    rx_perr_a,    0);
    check("reset_rx_ferr",    rx_ferr_a,    0);
    check("reset_rx_overrun", rx_overrun_a, 0);
    check("reset_fsm_states", {dbg_tx_a, dbg_rx_a}, 0);
    rst_n = 1'b1; rst_c = 1'b1;
    tick(2);

    // ---- A: TX latency, frame period, loopback ----
    tx_data_a = 8'h55; tx_valid_a = 1'b1;
    tick(1);                       // accepting edge passed
    tx_valid_a = 1'b0;
    tick(1);
    check("tx_latency_1clk_high", uart_tx_a, 1);
    tick(1);
    check("tx_latency_2clk_low",  uart_tx_a, 0);
    tx_data_a = 8'hA3; tx_valid_a = 1'b1;
    tick(1);
    tx_data_a = 8'h0D;
    tick(1);
    tx_valid_a = 1'b0;
    tick(8637);
    check("frame1_last_clk_stop", uart_tx_a, 1);
    tick(1);
    check("frame2_start_8640",    uart_tx_a, 0);
    tick(8639);
    check("frame2_last_clk_stop", uart_tx_a, 1);
    tick(1);
    check("frame3_start_8640",    uart_tx_a, 0);
    tick(8639);
    check("tx_busy_before_end",   tx_busy_a, 1);
    tick(1);
    check("tx_busy_falls_at_end", tx_busy_a, 0);
    check("tx_idle_after_end",    uart_tx_a, 1);
    for (int i = 0; i < 3; i++) begin
      check("loop_rx_valid", rx_valid_a, 1);
      check("loop_rx_data",  rx_data_a,  exp_a[i]);
      check("loop_rx_flags", {rx_perr_a, rx_ferr_a}, 0);
      pop_a;
    end
    check("loop_rx_empty", rx_valid_a, 0);

    // ---- B: 7E2 parity ----
    b_frame(7'h41, 1'b1);
    check("par_bad_valid", rx_valid_b, 1);
    check("par_bad_data",  rx_data_b,  8'h41);
    check("par_bad_perr",  rx_perr_b,  1);
    check("par_bad_ferr",  rx_ferr_b,  0);
    pop_b;
    tick(64);
    b_frame(7'h41, 1'b0);
    check("par_ok_data",   rx_data_b,  8'h41);
    check("par_ok_perr",   rx_perr_b,  0);
    check("par_ok_ferr",   rx_ferr_b,  0);
    pop_b;
    check("par_ok_empty",  rx_valid_b, 0);

    // ---- C: framing error followed by a break ----
    c_frame(8'h5A, 1'b0);
    rx_line_c = 1'b0;
    tick(960);
    check("break_valid", rx_valid_c, 1);
    check("break_data",  rx_data_c,  8'h5A);
    check("break_ferr",  rx_ferr_c,  1);
    check("break_perr",  rx_perr_c,  0);
    pop_c;
    check("break_single_word", rx_valid_c, 0);
    rx_line_c = 1'b1;
    tick(64);
    check("break_release_no_word", rx_valid_c, 0);

    // ---- C: glitch rejected, then a good frame ----
    rx_line_c = 1'b0;
    tick(8);
    rx_line_c = 1'b1;
    tick(64);
    check("glitch_no_word", rx_valid_c, 0);
    check("glitch_rx_idle", dbg_rx_c,   0);
    c_frame(8'hC3, 1'b1);
    tick(32);
    check("after_glitch_data", rx_data_c, 8'hC3);
    check("after_glitch_ferr", rx_ferr_c, 0);
    pop_c;

    // ---- C: overrun with FIFO_DEPTH 4 ----
    ovr_start = ovr_cnt;
    c_frame(8'h11, 1'b1);
    c_frame(8'h22, 1'b1);
    c_frame(8'h33, 1'b1);
    c_frame(8'h44, 1'b1);
    c_frame(8'h55, 1'b1);
    c_frame(8'h66, 1'b1);
    tick(32);
    check("ovr_pulses", ovr_cnt - ovr_start, 2);
    check("ovr_valid",  rx_valid_c, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_pop_data", rx_data_c, exp_c[i]);
      pop_c;
    end
    check("ovr_empty", rx_valid_c, 0);

    // ---- C: reset during the 4th data bit of a TX frame ----
    tx_data_c = 8'h12; tx_valid_c = 1'b1;
    tick(1);
    tx_data_c = 8'h34;
    tick(1);
    tx_data_c = 8'h56;
    tick(1);
    tx_valid_c = 1'b0;
    tick(144);                     // mid data bit 3 of 0x12 (a 0)
    check("pre_reset_line_bit3", uart_tx_c, 0);
    check("pre_reset_busy",      tx_busy_c, 1);
    #2 rst_c = 1'b0;
    #1;
    check("reset_async_uart_tx", uart_tx_c,  1);
    check("reset_async_busy",    tx_busy_c,  0);
    check("reset_async_ready",   tx_ready_c, 1);
    tick(2);
    rst_c = 1'b1;
    tick(2);
    tx_data_c = 8'h7E; tx_valid_c = 1'b1;
    tick(1);
    tx_valid_c = 1'b0;
    tick(17);                      // centre of start bit
    for (int k = 0; k < 10; k++) begin
      check("tx_7e_bit", uart_tx_c, frame_7e[k]);
      tick(32);
    end
    check("tx_7e_done_busy", tx_busy_c, 0);
    check("tx_7e_done_line", uart_tx_c, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
